// File: rtl/uart_rx_fsm_if.sv
// UART receiver control bundle: line, frame options and check-stage flags
// toward the FSM; counters, stage enables and frame result pulses back out.
//   rx_in, par_en, start_glitch, par_err, stop_err : into the FSM
//   edge_cnt, bit_cnt, *_en, data_valid, frame_error, parity_error : out
interface uart_rx_fsm_if #(
   parameter int PRESCALE   = 8,
   parameter int DATA_WIDTH = 8
);
   localparam int EW = $clog2(PRESCALE);
   localparam int BW = $clog2(DATA_WIDTH + 1);

   logic          rx_in;
   logic          par_en;
   logic          start_glitch;
   logic          par_err;
   logic          stop_err;
   logic [EW-1:0] edge_cnt;
   logic [BW-1:0] bit_cnt;
   logic          dat_samp_en;
   logic          start_chk_en;
   logic          deser_en;
   logic          par_chk_en;
   logic          stop_chk_en;
   logic          data_valid;
   logic          frame_error;
   logic          parity_error;

   modport master (
      output rx_in, par_en, start_glitch, par_err, stop_err,
      input  edge_cnt, bit_cnt, dat_samp_en, start_chk_en,
      input  deser_en, par_chk_en, stop_chk_en,
      input  data_valid, frame_error, parity_error
   );

   modport slave (
      input  rx_in, par_en, start_glitch, par_err, stop_err,
      output edge_cnt, bit_cnt, dat_samp_en, start_chk_en,
      output deser_en, par_chk_en, stop_chk_en,
      output data_valid, frame_error, parity_error
   );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receiver control FSM: start detect, oversample/bit counters,
// frame phase sequencing, check-stage enables and frame result pulses.
//   clk, rst : clock, synchronous active-high reset
//   bus      : uart_rx_fsm_if.slave (line, flags in; counters, enables,
//              data_valid / frame_error / parity_error out)
module uart_rx_fsm #(
   parameter int PRESCALE   = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   uart_rx_fsm_if.slave bus
);
   localparam int EW = $clog2(PRESCALE);
   localparam int BW = $clog2(DATA_WIDTH + 1);

   // first phase where sampler majority and check flags are settled
   localparam logic [EW-1:0] SAMP  = EW'(PRESCALE / 2 + 2);
   localparam logic [EW-1:0] LAST  = EW'(PRESCALE - 1);
   localparam logic [BW-1:0] B_END = BW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t        state_q, state_d;
   logic [EW-1:0] edge_q, edge_d;
   logic [BW-1:0] bit_q, bit_d;
   logic          par_latch_q, par_latch_d;
   logic          dv_q, fe_q, pe_q;
   logic          frame_done;
   logic          at_last, samp_win;
   logic          samp_en, start_en, deser, par_en_o, stop_en;

   always_comb begin
      at_last     = (edge_q == LAST);
      samp_win    = (edge_q >= SAMP);
      state_d     = state_q;
      edge_d      = at_last ? '0 : edge_q + EW'(1);
      bit_d       = bit_q;
      par_latch_d = par_latch_q;
      frame_done  = 1'b0;
      samp_en     = 1'b1;
      start_en    = 1'b0;
      deser       = 1'b0;
      par_en_o    = 1'b0;
      stop_en     = 1'b0;

      unique case (state_q)
         IDLE: begin
            samp_en = 1'b0;
            edge_d  = '0;
            bit_d   = '0;
            if (!bus.rx_in) begin
               state_d     = START;
               par_latch_d = 1'b0;
            end
         end
         START: begin
            start_en = samp_win;
            if (at_last) begin
               bit_d   = '0;
               state_d = bus.start_glitch ? IDLE : DATA;
            end
         end
         DATA: begin
            deser = (edge_q == SAMP);
            if (at_last) begin
               if (bit_q == B_END) begin
                  bit_d   = '0;
                  state_d = bus.par_en ? PARITY : STOP;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         PARITY: begin
            par_en_o = samp_win;
            if (at_last) begin
               par_latch_d = bus.par_err;
               state_d     = STOP;
            end
         end
         STOP: begin
            stop_en = samp_win;
            if (at_last) begin
               frame_done = 1'b1;
               state_d    = IDLE;
            end
         end
         default: begin
            samp_en = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         edge_q      <= '0;
         bit_q       <= '0;
         par_latch_q <= 1'b0;
         dv_q        <= 1'b0;
         fe_q        <= 1'b0;
         pe_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         edge_q      <= edge_d;
         bit_q       <= bit_d;
         par_latch_q <= par_latch_d;
         dv_q        <= frame_done & ~bus.stop_err & ~par_latch_q;
         fe_q        <= frame_done & bus.stop_err;
         pe_q        <= frame_done & par_latch_q;
      end
   end

   assign bus.edge_cnt     = edge_q;
   assign bus.bit_cnt      = bit_q;
   assign bus.dat_samp_en  = samp_en;
   assign bus.start_chk_en = start_en;
   assign bus.deser_en     = deser;
   assign bus.par_chk_en   = par_en_o;
   assign bus.stop_chk_en  = stop_en;
   assign bus.data_valid   = dv_q;
   assign bus.frame_error  = fe_q;
   assign bus.parity_error = pe_q;
endmodule
